cla_add_arbiter: RTL and testbench

//   Shares one 32-bit carry-lookahead adder (A,B -> 33-bit Sum) between N_REQ requesters.

---
 rtl/cla_add_arbiter_if.sv | 28 ++
 rtl/cla_add_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_cla_add_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_add_arbiter_if.sv
// Purpose : request/response bundle between the ALU-side clients and the shared adder arbiter.
// Ports   : req_valid/req_ready/req_a/req_b (per-requester operand handshake, 32-bit slices),
//           rsp_valid/rsp_ready/rsp_sum/rsp_id (single result port, 33-bit sum plus owner ID).
interface cla_add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [32:0]         rsp_sum;
  logic [ID_W-1:0]     rsp_id;

  // Client side: presents operands, consumes results.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_id
  );
endinterface

// File: rtl/cla_add_arbiter.sv
// Purpose : round-robin share of one 32-bit carry-lookahead adder among N_REQ requesters.
//           Latency: ready seen in cycle T, registered result valid in cycle T+2; 1 op / 3 cycles.
//           Backpressure: result held stable until rsp_ready; no requester is readied meanwhile.
// Ports   : clk, rst_n (async active-low), bus (cla_add_arbiter_if.slave), busy (state != IDLE).
//           Optional macro ADD_ARB_STATS_EN adds stat_grant (N_REQ x 16-bit saturating grant
//           counts) and stat_cout (16-bit saturating count of results with carry-out set).
module cla_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_add_arbiter_if.slave      bus,
  output logic                  busy
`ifdef ADD_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]   stat_grant,
  output logic [15:0]           stat_cout
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      state_q,     state_d;
  logic [31:0]     op_a_q,      op_a_d;
  logic [31:0]     op_b_q,      op_b_d;
  logic [ID_W-1:0] id_q,        id_d;
  logic [ID_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic [32:0]     rsp_sum_q,   rsp_sum_d;
  logic            rsp_valid_q, rsp_valid_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first valid requester strictly after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  logic            found_w;
  logic [ID_W-1:0] winner_w;
  logic [31:0]     sel_a_w;
  logic [31:0]     sel_b_w;

  always_comb begin
    found_w  = 1'b0;
    winner_w = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      int unsigned     idx;
      logic [ID_W-1:0] idx_w;
      idx   = (int'(rr_ptr_q) + k) % N_REQ;
      idx_w = ID_W'(idx);
      if (!found_w && bus.req_valid[idx_w]) begin
        found_w  = 1'b1;
        winner_w = idx_w;
      end
    end
  end

  // Operand mux with constant slices only.
  always_comb begin
    sel_a_w = '0;
    sel_b_w = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner_w == ID_W'(k)) begin
        sel_a_w = bus.req_a[k*32 +: 32];
        sel_b_w = bus.req_b[k*32 +: 32];
      end
    end
  end

  // Ready is gated by rst_n so every output reads zero while reset is held,
  // even if requesters keep valid asserted through it.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && state_q == ST_IDLE && found_w) begin
      bus.req_ready[winner_w] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared adder: 4-bit lookahead blocks, block carries chained through group G/P.
  // ---------------------------------------------------------------------------
  logic [31:0] p_w, g_w, c_w;
  logic [7:0]  gg_w, gp_w;
  logic [8:0]  bc_w;
  logic [32:0] sum_w;

  always_comb begin
    p_w  = op_a_q ^ op_b_q;
    g_w  = op_a_q & op_b_q;
    gg_w = '0;
    gp_w = '0;
    bc_w = '0;
    c_w  = '0;
    for (int k = 0; k < 8; k++) begin
      gp_w[k] = &p_w[k*4 +: 4];
      gg_w[k] = g_w[k*4+3]
              | (p_w[k*4+3] & g_w[k*4+2])
              | (p_w[k*4+3] & p_w[k*4+2] & g_w[k*4+1])
              | (p_w[k*4+3] & p_w[k*4+2] & p_w[k*4+1] & g_w[k*4]);
    end
    for (int k = 0; k < 8; k++) begin
      bc_w[k+1] = gg_w[k] | (gp_w[k] & bc_w[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c_w[k*4]   = bc_w[k];
      c_w[k*4+1] = g_w[k*4] | (p_w[k*4] & bc_w[k]);
      c_w[k*4+2] = g_w[k*4+1] | (p_w[k*4+1] & g_w[k*4])
                 | (p_w[k*4+1] & p_w[k*4] & bc_w[k]);
      c_w[k*4+3] = g_w[k*4+2] | (p_w[k*4+2] & g_w[k*4+1])
                 | (p_w[k*4+2] & p_w[k*4+1] & g_w[k*4])
                 | (p_w[k*4+2] & p_w[k*4+1] & p_w[k*4] & bc_w[k]);
    end
    sum_w = {bc_w[8], p_w ^ c_w};
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (found_w) begin
          op_a_d   = sel_a_w;
          op_b_d   = sel_b_w;
          id_d     = winner_w;
          rr_ptr_d = winner_w;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_sum_d   = sum_w;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= '0;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      rsp_sum_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_id    = id_q;
  assign busy          = (state_q != ST_IDLE);

`ifdef ADD_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0][15:0] stat_grant_q;
  logic [15:0]            stat_cout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant_q <= '0;
      stat_cout_q  <= '0;
    end else begin
      if (state_q == ST_IDLE && found_w && stat_grant_q[winner_w] != 16'hFFFF) begin
        stat_grant_q[winner_w] <= stat_grant_q[winner_w] + 16'd1;
      end
      if (state_q == ST_EXEC && sum_w[32] && stat_cout_q != 16'hFFFF) begin
        stat_cout_q <= stat_cout_q + 16'd1;
      end
    end
  end

  assign stat_grant = stat_grant_q;
  assign stat_cout  = stat_cout_q;
`endif

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Purpose : self-checking bench for cla_add_arbiter (4 requesters): directed corner cases
//           followed by randomized traffic checked against a transaction-level model.
// Ports   : none; drives the DUT through an instance of cla_add_arbiter_if.
module tb_cla_add_arbiter;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic busy;
`ifdef ADD_ARB_STATS_EN
  logic [N*16-1:0] stat_grant;
  logic [15:0]     stat_cout;
`endif

  cla_add_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();

  cla_add_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
`ifdef ADD_ARB_STATS_EN
    ,
    .stat_grant (stat_grant),
    .stat_cout  (stat_cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model state (transaction level).
  logic [N-1:0] vld;
  logic [31:0]  aa [N];
  logic [31:0]  bb [N];
  int           last_g;
  int           grants [N];
  int           couts;
  int           got_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first valid index after the last grant, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    bus.req_valid = vld;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*32 +: 32] = aa[i];
      bus.req_b[i*32 +: 32] = bb[i];
    end
  endtask

  task automatic model_reset();
    last_g = N - 1;
    couts  = 0;
    for (int i = 0; i < N; i++) grants[i] = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    vld = '1;
    drive();
    rst_n = 1'b0;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_sum",   bus.rsp_sum, 0);
    chk("rst_id",    bus.rsp_id, 0);
    chk("rst_busy",  busy, 0);
    @(negedge clk);
    vld = '0;
    drive();
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  // One transaction starting in an IDLE cycle; rsp_ready low for 'hold' RESP cycles.
  task automatic txn(input int hold);
    int          w;
    logic [32:0] es;
    drive();
    #1;
    w = rr_pick(last_g, vld);
    chk("grant_ready", bus.req_ready, (w < 0) ? 64'd0 : (64'd1 << w));
    chk("idle_busy", busy, 0);
    if (w < 0) begin
      @(negedge clk);
      return;
    end
    es = {1'b0, aa[w]} + {1'b0, bb[w]};
    @(negedge clk);
    last_g = w;
    grants[w]++;
    vld[w] = 1'b0;
    drive();
    #1;
    chk("exec_ready", bus.req_ready, 0);
    chk("exec_busy",  busy, 1);
    chk("exec_valid", bus.rsp_valid, 0);
    @(negedge clk);
    if (es[32]) couts++;
    bus.rsp_ready = (hold == 0);
    #1;
    chk("resp_valid", bus.rsp_valid, 1);
    chk("resp_sum",   bus.rsp_sum, es);
    chk("resp_id",    bus.rsp_id, w);
    chk("resp_ready", bus.req_ready, 0);
    got_id = int'(bus.rsp_id);
    for (int h = 1; h <= hold; h++) begin
      @(negedge clk);
      bus.rsp_ready = (h == hold);
      #1;
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_sum",   bus.rsp_sum, es);
      chk("hold_id",    bus.rsp_id, w);
      chk("hold_ready", bus.req_ready, 0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'($urandom_range(0, 1));
    #1;
    chk("done_valid", bus.rsp_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    vld = '0;
    for (int i = 0; i < N; i++) begin
      aa[i] = '0;
      bb[i] = '0;
    end
    bus.rsp_ready = 1'b0;
    drive();
    model_reset();
    got_id = -1;

    // 1: single requester, carry out of the top bit.
    do_reset();
    vld = 4'b0001; aa[0] = 32'hFFFF_FFFF; bb[0] = 32'h1;
    txn(0);
    chk("t1_id", got_id, 0);

    // 2: all requesters continuously valid, strict rotation from 0.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i]) begin
          vld[i] = 1'b1;
          aa[i]  = 32'h1000_0000 * (i + 1) + k;
          bb[i]  = 32'h0300_0000 + 32'(k * 7);
        end
      end
      txn(0);
      chk("t2_rotation", got_id, k % N);
    end

    // 3: response backpressure for five cycles.
    vld = '0;
    vld[2] = 1'b1; aa[2] = 32'h1234_5678; bb[2] = 32'h1;
    txn(5);

    // 4: reset while EXEC; in-flight op dropped, priority restarts at 0.
    vld = '0;
    vld[2] = 1'b1; aa[2] = 32'hDEAD_0000; bb[2] = 32'h0000_BEEF;
    drive();
    @(negedge clk);
    #1;
    chk("t4_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", bus.rsp_valid, 0);
    chk("t4_rst_busy",  busy, 0);
    chk("t4_rst_id",    bus.rsp_id, 0);
    chk("t4_rst_sum",   bus.rsp_sum, 0);
    chk("t4_rst_ready", bus.req_ready, 0);
    @(negedge clk);
    vld = '0;
    drive();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("t4_no_rsp", bus.rsp_valid, 0);
    end
    vld = 4'b1010;
    aa[1] = 32'h5; bb[1] = 32'h6; aa[3] = 32'h7; bb[3] = 32'h8;
    txn(0);
    chk("t4_first", got_id, 1);
    txn(1);
    chk("t4_second", got_id, 3);

    // 5: MSB carry and all-zero operands.
    vld = 4'b0001; aa[0] = 32'h8000_0000; bb[0] = 32'h8000_0000;
    txn(0);
    vld = 4'b0001; aa[0] = 32'h0; bb[0] = 32'h0;
    txn(2);

`ifdef ADD_ARB_STATS_EN
    // 6: statistics after three grants to req 2 plus one carry-out op on req 0.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      vld = 4'b0100; aa[2] = 32'(k + 1); bb[2] = 32'h10;
      txn(0);
    end
    vld = 4'b0001; aa[0] = 32'hFFFF_FFFF; bb[0] = 32'h1;
    txn(0);
    chk("t6_grant2", stat_grant[2*16 +: 16], 3);
    chk("t6_grant0", stat_grant[0 +: 16], 1);
    chk("t6_cout",   stat_cout, 1);
`endif

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && $urandom_range(0, 2) != 0) begin
          vld[i] = 1'b1;
          aa[i]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 15) : $urandom;
          bb[i]  = $urandom;
        end else if (vld[i] && $urandom_range(0, 9) == 0) begin
          vld[i] = 1'b0;
        end
      end
      txn($urandom_range(0, 3));
    end

`ifdef ADD_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      chk("rand_grant", stat_grant[i*16 +: 16], grants[i]);
    end
    chk("rand_cout", stat_cout, couts);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
